// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: icache miss path with one L2 line refill at a time, beat fill streaming and per-set 2-way LRU.
// The optional counters perf_miss_count and perf_busy_cycles exist only when ICACHE_REFILL_PERF_CNT_EN is defined.
module icache_refill_ctrl #(
  parameter int ICACHE_NUM_SETS  = 64,
  parameter int ICACHE_TAG_WIDTH = 22,
  parameter int BEATS_PER_LINE   = 2,
  localparam int INDEX_W = $clog2(ICACHE_NUM_SETS),
  localparam int BEAT_W  = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          miss_valid,
  input  logic [ICACHE_TAG_WIDTH-1:0]   miss_tag,
  input  logic [INDEX_W-1:0]            miss_index,
  input  logic                          hit_valid,
  input  logic                          hit_way,
  input  logic [INDEX_W-1:0]            hit_index,
  input  logic                          restart_valid,
  output logic                          l2_req_valid,
  input  logic                          l2_req_ready,
  output logic [ICACHE_TAG_WIDTH+INDEX_W-1:0] l2_req_block_addr,
  input  logic                          l2_resp_valid,
  input  logic [127:0]                  l2_resp_data,
  input  logic                          l2_resp_error,
  output logic                          fill_valid,
  output logic                          fill_way,
  output logic [INDEX_W-1:0]            fill_index,
  output logic [BEAT_W-1:0]             fill_beat,
  output logic [127:0]                  fill_data,
  output logic                          tag_write_valid,
  output logic [ICACHE_TAG_WIDTH-1:0]   tag_write_tag,
  output logic                          busy,
  output logic                          miss_done,
  output logic                          miss_access_fault
`ifdef ICACHE_REFILL_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_miss_count,
  output logic [31:0]                   perf_busy_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t                        r_state, w_next;
  logic [ICACHE_TAG_WIDTH-1:0]   r_tag;
  logic [INDEX_W-1:0]            r_index;
  logic                          r_victim;
  logic [BEAT_W-1:0]             r_cnt;
  logic                          r_err, r_squash, r_done, r_fault;
  logic [ICACHE_NUM_SETS-1:0]    r_lru;
  logic                          w_beat, w_last, w_err, w_accept;
  assign w_accept = (r_state == IDLE) & miss_valid;
  assign w_beat   = (r_state == WAIT) & l2_resp_valid;
  assign w_last   = w_beat & (r_cnt == BEAT_W'(BEATS_PER_LINE - 1));
  assign w_err    = r_err | l2_resp_error;
  assign l2_req_valid      = (r_state == REQ);
  assign l2_req_block_addr = {r_tag, r_index};
  assign fill_valid        = w_beat;
  assign fill_way          = w_beat & r_victim;
  assign fill_index        = w_beat ? r_index : '0;
  assign fill_beat         = w_beat ? r_cnt : '0;
  assign fill_data         = w_beat ? l2_resp_data : '0;
  assign tag_write_valid   = w_last & ~w_err;
  assign tag_write_tag     = tag_write_valid ? r_tag : '0;
  assign busy              = (r_state != IDLE);
  assign miss_done         = r_done;
  assign miss_access_fault = r_fault;
  // Next-state selection: a request accepted together with a restart still counts as sent.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = miss_valid ? REQ : IDLE;
      REQ:     w_next = l2_req_ready ? WAIT : (restart_valid ? IDLE : REQ);
      WAIT:    w_next = w_last ? IDLE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // Miss capture, beat counter, sticky error and squash tracking for the outstanding refill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_tag    <= '0;
      r_index  <= '0;
      r_victim <= 1'b0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_squash <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tag    <= miss_tag;
        r_index  <= miss_index;
        r_victim <= r_lru[miss_index];
      end
      r_cnt    <= w_last ? '0 : (w_beat ? r_cnt + 1'b1 : r_cnt);
      r_err    <= w_last ? 1'b0 : (w_beat ? w_err : r_err);
      r_squash <= w_last ? 1'b0
                : ((r_state == REQ) & l2_req_ready & restart_valid) | ((r_state == WAIT) & restart_valid) | r_squash;
    end
  end
  // Completion pulses, one cycle after the last beat; a restart during that beat also suppresses them.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_done  <= w_last & ~(r_squash | restart_valid) & ~w_err;
      r_fault <= w_last & ~(r_squash | restart_valid) & w_err;
    end
  end
  // LRU bit per set holds the least-recently-used way; the fill update is written last so it wins a collision.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_lru <= '0;
    else begin
      if (hit_valid) r_lru[hit_index] <= ~hit_way;
      if (tag_write_valid) r_lru[r_index] <= ~r_victim;
    end
  end
`ifdef ICACHE_REFILL_PERF_CNT_EN
  // Free-running wrap-around counters of accepted misses and busy cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_miss_count  <= '0;
      perf_busy_cycles <= '0;
    end else begin
      perf_miss_count  <= perf_miss_count + {31'd0, w_accept};
      perf_busy_cycles <= perf_busy_cycles + {31'd0, busy};
    end
  end
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized refill traffic checked against a per-set LRU reference model.
module tb_icache_refill_ctrl;
  logic         CLK = 1'b0;
  logic         nRST;
  logic         miss_valid, hit_valid, hit_way, restart_valid, l2_req_ready;
  logic         l2_resp_valid, l2_resp_error;
  logic [21:0]  miss_tag;
  logic [5:0]   miss_index, hit_index;
  logic [127:0] l2_resp_data;
  logic         l2_req_valid, fill_valid, fill_way, tag_write_valid, busy, miss_done, miss_access_fault;
  logic [27:0]  l2_req_block_addr;
  logic [5:0]   fill_index;
  logic [0:0]   fill_beat;
  logic [127:0] fill_data;
  logic [21:0]  tag_write_tag;
  int n_checks = 0;
  int n_errors = 0;
  bit m_lru [64];
  icache_refill_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .miss_valid(miss_valid), .miss_tag(miss_tag), .miss_index(miss_index),
    .hit_valid(hit_valid), .hit_way(hit_way), .hit_index(hit_index),
    .restart_valid(restart_valid),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_block_addr(l2_req_block_addr),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data), .l2_resp_error(l2_resp_error),
    .fill_valid(fill_valid), .fill_way(fill_way), .fill_index(fill_index), .fill_beat(fill_beat),
    .fill_data(fill_data), .tag_write_valid(tag_write_valid), .tag_write_tag(tag_write_tag),
    .busy(busy), .miss_done(miss_done), .miss_access_fault(miss_access_fault)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic do_hit(input logic w, input logic [5:0] ix);
    hit_valid = 1'b1;
    hit_way = w;
    hit_index = ix;
    tick;
    hit_valid = 1'b0;
    m_lru[ix] = ~w;
    #1;
  endtask
  task automatic stray_beat;
    l2_resp_valid = 1'b1;
    l2_resp_data = {$urandom, $urandom, $urandom, $urandom};
    #1 check("idle_stray_nofill", fill_valid, 0);
    tick;
    l2_resp_valid = 1'b0;
    #1;
  endtask
  // rs: 0 none, 1 restart in REQ without ready, 2 restart in WAIT, 3 restart together with ready
  task automatic run_miss(input logic [21:0] tg, input logic [5:0] ix, input int rdy, input int gap,
                          input logic [1:0] em, input int rs, input bit hol, input logic hw, input logic [5:0] hi);
    logic v;
    logic [127:0] d;
    bit sq;
    v = m_lru[ix];
    sq = (rs >= 2);
    miss_valid = 1'b1;
    miss_tag = tg;
    miss_index = ix;
    #1 check("idle_not_busy", busy, 0);
    tick;
    miss_valid = 1'b0;
    #1;
    check("req_valid", l2_req_valid, 1);
    check("req_addr", l2_req_block_addr, {tg, ix});
    check("pulse_one_cycle", {miss_done, miss_access_fault}, 0);
    for (int k = 0; k < rdy; k++) begin
      tick;
      #1;
      check("req_hold_valid", l2_req_valid, 1);
      check("req_hold_addr", l2_req_block_addr, {tg, ix});
    end
    if (rs == 1) begin
      restart_valid = 1'b1;
      tick;
      restart_valid = 1'b0;
      #1;
      check("req_squash_idle", busy, 0);
      check("req_squash_noreq", l2_req_valid, 0);
      return;
    end
    l2_req_ready = 1'b1;
    restart_valid = (rs == 3);
    tick;
    l2_req_ready = 1'b0;
    restart_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      #1 check("wait_gap_nofill", {fill_valid, busy}, 2'b01);
      tick;
    end
    for (int b = 0; b < 2; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      l2_resp_valid = 1'b1;
      l2_resp_data = d;
      l2_resp_error = em[b];
      restart_valid = (rs == 2 && b == 0);
      if (b == 1 && hol) begin
        hit_valid = 1'b1;
        hit_way = hw;
        hit_index = hi;
      end
      #1;
      check("fill_valid", fill_valid, 1);
      check("fill_way", fill_way, v);
      check("fill_index", fill_index, ix);
      check("fill_beat", fill_beat, b[0]);
      check("fill_data", fill_data, d);
      check("tag_write_valid", tag_write_valid, (b == 1 && em == 0));
      if (b == 1 && em == 0) check("tag_write_tag", tag_write_tag, tg);
      check("busy_in_wait", busy, 1);
      tick;
      l2_resp_valid = 1'b0;
      l2_resp_error = 1'b0;
      restart_valid = 1'b0;
      hit_valid = 1'b0;
    end
    if (hol) m_lru[hi] = ~hw;
    if (em == 0) m_lru[ix] = ~v;
    #1;
    check("miss_done", miss_done, (!sq && em == 0));
    check("miss_access_fault", miss_access_fault, (!sq && em != 0));
    check("idle_after_fill", busy, 0);
  endtask
  task automatic reset_mid_refill;
    miss_valid = 1'b1;
    miss_tag = 22'h2AAAA;
    miss_index = 6'd9;
    tick;
    miss_valid = 1'b0;
    l2_req_ready = 1'b1;
    tick;
    l2_req_ready = 1'b0;
    l2_resp_valid = 1'b1;
    l2_resp_data = {4{32'hDEADBEEF}};
    tick;
    nRST = 1'b0;
    foreach (m_lru[i]) m_lru[i] = 1'b0;
    #1;
    check("rst_ctrl_outputs", {l2_req_valid, busy, fill_valid, tag_write_valid, miss_done, miss_access_fault}, 0);
    check("rst_fill_fields", {fill_way, fill_index, fill_beat, tag_write_tag, l2_req_block_addr}, 0);
    check("rst_fill_data", fill_data, 0);
    tick;
    nRST = 1'b1;
    #1;
    check("post_rst_stray_nofill", fill_valid, 0);
    check("post_rst_idle", busy, 0);
    tick;
    l2_resp_valid = 1'b0;
    #1;
  endtask
  initial begin
    nRST = 1'b0;
    {miss_valid, hit_valid, hit_way, restart_valid, l2_req_ready, l2_resp_valid, l2_resp_error} = '0;
    miss_tag = '0;
    miss_index = '0;
    hit_index = '0;
    l2_resp_data = '0;
    foreach (m_lru[i]) m_lru[i] = 1'b0;
    #3;
    check("reset_ctrl_outputs", {l2_req_valid, busy, fill_valid, tag_write_valid, miss_done, miss_access_fault}, 0);
    check("reset_addr", l2_req_block_addr, 0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    #1;
    run_miss(22'h12345, 6'd5, 0, 0, 2'b00, 0, 0, 0, 0);
    run_miss(22'h00111, 6'd5, 0, 1, 2'b00, 0, 0, 0, 0);
    do_hit(1'b0, 6'd7);
    run_miss(22'h00777, 6'd7, 0, 0, 2'b00, 0, 0, 0, 0);
    run_miss(22'h00333, 6'd3, 0, 0, 2'b00, 0, 1, 1'b1, 6'd3);
    run_miss(22'h00334, 6'd3, 1, 0, 2'b00, 0, 0, 0, 0);
    run_miss(22'h00EEE, 6'd11, 0, 0, 2'b01, 0, 0, 0, 0);
    run_miss(22'h00EEF, 6'd11, 0, 0, 2'b00, 0, 0, 0, 0);
    run_miss(22'h00AAA, 6'd12, 2, 0, 2'b00, 1, 0, 0, 0);
    run_miss(22'h00BBB, 6'd12, 0, 0, 2'b00, 2, 0, 0, 0);
    run_miss(22'h00CCC, 6'd13, 0, 0, 2'b00, 3, 0, 0, 0);
    run_miss(22'h3FFFF, 6'd63, 10, 0, 2'b00, 0, 0, 0, 0);
    stray_beat;
    reset_mid_refill;
    run_miss(22'h12346, 6'd5, 0, 0, 2'b00, 0, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 5);
      if (op == 0) do_hit(1'($urandom), 6'($urandom_range(0, 7)));
      else if (op == 1) stray_beat;
      else run_miss(22'($urandom), 6'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                    1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
